// File: rtl/output_display_if.sv
// -----------------------------------------------------------------------------
// output_display_if
// Bundles the load handshake and the display-side outputs of output_display.
//   ld     : load strobe from the output-register load enable
//   data   : 8-bit value to display, sampled when ld=1
//   seg    : segments {g,f,e,d,c,b,a}
//   an     : active-low one-hot digit enables, an[0] = rightmost digit
//   busy   : BCD conversion in progress
//   valid  : at least one conversion completed since reset
// master : the output-register side (drives ld/data)
// slave  : the display block
// -----------------------------------------------------------------------------
interface output_display_if;
   logic       ld;
   logic [7:0] data;
   logic [6:0] seg;
   logic [3:0] an;
   logic       busy;
   logic       valid;

   modport master (output ld, data, input seg, an, busy, valid);
   modport slave  (input ld, data, output seg, an, busy, valid);
endinterface

// File: rtl/output_display.sv
// -----------------------------------------------------------------------------
// output_display
// Captures the CPU output register on each load strobe, converts it to BCD
// with a sequential shift-add-3 (one bit per clock) and drives a 4-digit
// time-multiplexed 7-segment display with leading-zero blanking.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : output_display_if.slave (ld, data, seg, an, busy, valid)
// Parameters:
//   REFRESH_DIV    : clocks each digit stays enabled (>= 1)
//   SEG_ACTIVE_LOW : 1 inverts seg (an polarity unaffected)
// Build option:
//   OUTPUT_DISPLAY_SIGNED_EN : data is two's complement; the magnitude is
//   converted through a 9-bit shift register (9 iterations) and digit 3 shows
//   a minus sign for negative values.
// -----------------------------------------------------------------------------
module output_display #(
   parameter int REFRESH_DIV    = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   output_display_if.slave   bus
);

`ifdef OUTPUT_DISPLAY_SIGNED_EN
   localparam int SW = 9;   // 9 bits so that -128 gives magnitude 128
`else
   localparam int SW = 8;
`endif
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   typedef enum logic {IDLE, CONV} state_t;

   state_t          state_q;
   logic [SW-1:0]   sh_q, sh_d, mag_d;
   logic [11:0]     bcd_q, bcd_d, bcd_adj;
   logic [3:0]      it_q;
   logic            busy_q, valid_q, neg_q, neg_d;
   logic [3:0][6:0] dig_q, dig_d;
   logic [CW-1:0]   rcnt_q;
   logic [1:0]      idx_q, idx_d;
   logic [6:0]      seg_q;
   logic [3:0]      an_q;

   function automatic logic [6:0] enc(input logic [3:0] v);
      case (v)
         4'd0:    enc = 7'h3F;
         4'd1:    enc = 7'h06;
         4'd2:    enc = 7'h5B;
         4'd3:    enc = 7'h4F;
         4'd4:    enc = 7'h66;
         4'd5:    enc = 7'h6D;
         4'd6:    enc = 7'h7D;
         4'd7:    enc = 7'h07;
         4'd8:    enc = 7'h7F;
         4'd9:    enc = 7'h6F;
         default: enc = 7'h00;
      endcase
   endfunction

   // Value to load: raw data, or its magnitude in the signed build.
   always_comb begin
`ifdef OUTPUT_DISPLAY_SIGNED_EN
      neg_d = bus.data[7];
      mag_d = bus.data[7] ? (9'h100 - {1'b0, bus.data}) : {1'b0, bus.data};
`else
      neg_d = 1'b0;
      mag_d = bus.data;
`endif
   end

   // One shift-add-3 step, and the digit codes the final step would produce.
   always_comb begin
      bcd_adj = bcd_q;
      for (int n = 0; n < 3; n++)
         if (bcd_q[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
      bcd_d = {bcd_adj[10:0], sh_q[SW-1]};
      sh_d  = sh_q << 1;
      dig_d[0] = enc(bcd_d[3:0]);
      dig_d[1] = (bcd_d[11:8] == 4'd0 && bcd_d[7:4] == 4'd0) ? 7'h00 : enc(bcd_d[7:4]);
      dig_d[2] = (bcd_d[11:8] == 4'd0) ? 7'h00 : enc(bcd_d[11:8]);
      dig_d[3] = neg_q ? 7'h40 : 7'h00;
   end

   // Conversion FSM. A load in either state (re)starts the conversion, so a
   // superseded value never reaches the digit registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sh_q    <= '0;
         bcd_q   <= '0;
         it_q    <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         neg_q   <= 1'b0;
         dig_q   <= '0;
      end else if (bus.ld) begin
         state_q <= CONV;
         sh_q    <= mag_d;
         neg_q   <= neg_d;
         bcd_q   <= '0;
         it_q    <= '0;
         busy_q  <= 1'b1;
      end else if (state_q == CONV) begin
         sh_q  <= sh_d;
         bcd_q <= bcd_d;
         it_q  <= it_q + 4'd1;
         if (it_q == 4'(SW - 1)) begin
            dig_q   <= dig_d;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= IDLE;
         end
      end
   end

   // Digit mux: seg and an are both registered from the next index so they
   // always switch together.
   always_comb begin
      idx_d = (rcnt_q == CW'(REFRESH_DIV - 1)) ? idx_q + 2'd1 : idx_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt_q <= '0;
         idx_q  <= '0;
         an_q   <= 4'b1110;
         seg_q  <= {7{SEG_ACTIVE_LOW}};
      end else begin
         rcnt_q <= (rcnt_q == CW'(REFRESH_DIV - 1)) ? '0 : rcnt_q + CW'(1);
         idx_q  <= idx_d;
         an_q   <= ~(4'b0001 << idx_d);
         seg_q  <= dig_q[idx_d] ^ {7{SEG_ACTIVE_LOW}};
      end
   end

   assign bus.seg   = seg_q;
   assign bus.an    = an_q;
   assign bus.busy  = busy_q;
   assign bus.valid = valid_q;

endmodule

// File: tb/tb_output_display.sv
// Directed bench for output_display with REFRESH_DIV=4. Covers reset state,
// digit rotation, conversion latency, blanking, reload during conversion and
// reset mid-conversion. The signed build is exercised when the same macro is
// defined for the bench.
module tb_output_display;
`ifdef OUTPUT_DISPLAY_SIGNED_EN
   localparam int LAT = 9;
`else
   localparam int LAT = 8;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   output_display_if bus ();

   output_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] v);
      bus.data = v;
      bus.ld   = 1'b1;
      tick();
      bus.ld   = 1'b0;
      chk("busy_after_ld", {7'd0, bus.busy}, 8'd1);
   endtask

   // busy must stay high through LAT-1 more edges and drop on the LAT-th.
   task automatic finish_conv(input string tag);
      for (int i = 1; i < LAT; i++) begin
         tick();
         chk({tag, "_busy_hi"}, {7'd0, bus.busy}, 8'd1);
      end
      tick();
      chk({tag, "_busy_lo"}, {7'd0, bus.busy}, 8'd0);
      chk({tag, "_valid"}, {7'd0, bus.valid}, 8'd1);
   endtask

   // Wait for each digit to be enabled and compare its segments.
   task automatic show(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                       input logic [6:0] e2, input logic [6:0] e3);
      logic [6:0] exp_seg [4];
      logic [3:0] an_exp;
      exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
      tick();
      tick();
      for (int d = 0; d < 4; d++) begin
         int n;
         an_exp = ~(4'b0001 << d);
         n = 0;
         while (bus.an !== an_exp && n < 40) begin
            tick();
            n++;
         end
         chk($sformatf("%s_an%0d", tag, d), {4'd0, bus.an}, {4'd0, an_exp});
         chk($sformatf("%s_seg%0d", tag, d), {1'b0, bus.seg}, {1'b0, exp_seg[d]});
      end
   endtask

   initial begin
      logic [3:0] an_exp;
      bus.ld   = 1'b0;
      bus.data = 8'h00;

      // Reset held for 20 clocks.
      repeat (20) tick();
      chk("rst_an", {4'd0, bus.an}, 8'h0E);
      chk("rst_seg", {1'b0, bus.seg}, 8'h00);
      chk("rst_busy", {7'd0, bus.busy}, 8'd0);
      chk("rst_valid", {7'd0, bus.valid}, 8'd0);
      rst_n = 1'b1;

      // an rotates every 4 clocks; everything blank before the first result.
      for (int i = 1; i <= 16; i++) begin
         tick();
         an_exp = ~(4'b0001 << ((i / 4) % 4));
         chk($sformatf("rot_an_%0d", i), {4'd0, bus.an}, {4'd0, an_exp});
         chk($sformatf("rot_seg_%0d", i), {1'b0, bus.seg}, 8'h00);
      end
      chk("rot_valid", {7'd0, bus.valid}, 8'd0);

`ifdef OUTPUT_DISPLAY_SIGNED_EN
      load(8'hFF);
      finish_conv("m1");
      show("m1", 7'h06, 7'h00, 7'h00, 7'h40);
      load(8'h80);
      finish_conv("m128");
      show("m128", 7'h7F, 7'h5B, 7'h06, 7'h40);
      load(8'h7F);
      finish_conv("p127");
      show("p127", 7'h07, 7'h5B, 7'h06, 7'h00);
      load(8'h00);
      finish_conv("s0");
      show("s0", 7'h3F, 7'h00, 7'h00, 7'h00);
`else
      load(8'd0);
      finish_conv("d0");
      show("d0", 7'h3F, 7'h00, 7'h00, 7'h00);
      load(8'd255);
      finish_conv("d255");
      show("d255", 7'h6D, 7'h6D, 7'h5B, 7'h00);
      load(8'd105);
      finish_conv("d105");
      show("d105", 7'h6D, 7'h3F, 7'h06, 7'h00);
`endif
      load(8'd7);
      finish_conv("d7");
      show("d7", 7'h07, 7'h00, 7'h00, 7'h00);

      // Reload three clocks after the first load; 200 must never show and
      // the old value (7) must persist until the 42 result lands.
      load(8'd200);
      tick();
      chk("ovl_gap1_busy", {7'd0, bus.busy}, 8'd1);
      tick();
      chk("ovl_gap2_busy", {7'd0, bus.busy}, 8'd1);
      load(8'd42);
      for (int i = 1; i < LAT; i++) begin
         tick();
         chk($sformatf("ovl_busy_%0d", i), {7'd0, bus.busy}, 8'd1);
         chk($sformatf("ovl_old_%0d", i),
             {7'd0, (bus.seg === 7'h07 || bus.seg === 7'h00)}, 8'd1);
      end
      tick();
      chk("ovl_busy_lo", {7'd0, bus.busy}, 8'd0);
      show("d42", 7'h5B, 7'h66, 7'h00, 7'h00);

      // Reset in the middle of a conversion discards everything.
      load(8'd99);
      tick();
      tick();
      rst_n = 1'b0;
      #2;
      chk("mrst_busy", {7'd0, bus.busy}, 8'd0);
      chk("mrst_valid", {7'd0, bus.valid}, 8'd0);
      chk("mrst_an", {4'd0, bus.an}, 8'h0E);
      chk("mrst_seg", {1'b0, bus.seg}, 8'h00);
      tick();
      rst_n = 1'b1;
      repeat (12) begin
         tick();
         chk("mrst_blank", {1'b0, bus.seg}, 8'h00);
      end
      chk("mrst_valid2", {7'd0, bus.valid}, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
